// File: rtl/scan_sel_gen_if.sv
// Select/enable bundle between the scan sequencer and the 2-to-4 decoder side.
// The master drives run/step; the slave (scan_sel_gen) drives a/en/wrap.
interface scan_sel_gen_if;
  logic       run;
  logic       step;
  logic [1:0] a;
  logic       en;
  logic       wrap;

  modport master (
    output run,
    output step,
    input  a,
    input  en,
    input  wrap
  );

  modport slave (
    input  run,
    input  step,
    output a,
    output en,
    output wrap
  );
endinterface

// File: rtl/scan_sel_gen.sv
// Scan select generator: steps a 2-bit decoder select 0..3 with a blanked enable,
// plus freeze (HOLD) and single-step. Blanking is built only with SCAN_SEL_GEN_BLANK_EN.
module scan_sel_gen #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned BLANK    = 4
) (
  input  logic          clk,
  input  logic          rst,
  scan_sel_gen_if.slave bus
);

  localparam int unsigned   CW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [1:0]    a_q,     a_d;
  logic          en_q,    en_d;
  logic          wrap_q,  wrap_d;

  // Enable level for a SCAN cycle whose period count will be k.
  function automatic logic en_at(input logic [CW-1:0] k);
`ifdef SCAN_SEL_GEN_BLANK_EN
    return (k >= BLANK_C);
`else
    return 1'b1;
`endif
  endfunction

  // Next-state and next-output logic; outputs are computed one cycle ahead
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    en_d    = en_q;
    wrap_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        a_d   = 2'b00;
        if (bus.run) begin
          state_d = SCAN;
          en_d    = en_at(CNT_ZERO);
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      end

      SCAN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
          if (bus.run) begin
            state_d = SCAN;
            a_d     = a_q + 2'd1;
            wrap_d  = (a_q == 2'd3);
            en_d    = en_at(CNT_ZERO);
          end else begin
            state_d = HOLD;
            en_d    = 1'b1;
          end
        end else begin
          state_d = SCAN;
          cnt_d   = cnt_q + CNT_ONE;
          en_d    = en_at(cnt_q + CNT_ONE);
        end
      end

      HOLD: begin
        cnt_d = CNT_ZERO;
        // run and step together still produce a single advance
        if (bus.run || bus.step) begin
          state_d = SCAN;
          a_d     = a_q + 2'd1;
          wrap_d  = (a_q == 2'd3);
          en_d    = en_at(CNT_ZERO);
        end else begin
          state_d = HOLD;
          en_d    = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
        a_d     = 2'b00;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      a_q     <= 2'b00;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.a    = a_q;
  assign bus.en   = en_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Scoreboard bench for scan_sel_gen with PRESCALE=8, BLANK=2; enable
// expectations follow whether SCAN_SEL_GEN_BLANK_EN is defined.
module tb_scan_sel_gen;
  localparam int P = 8;
  localparam int B = 2;
`ifdef SCAN_SEL_GEN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_sel_gen_if bus ();

  scan_sel_gen #(.PRESCALE(P), .BLANK(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] a;
    logic       en;
    logic       wrap;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // expected enable for a SCAN cycle with period count k
  function automatic logic scan_en(input int k);
    return BLANK_EN ? (k >= B) : 1'b1;
  endfunction

  // drive inputs for the next edge and queue the outputs expected after it
  task automatic cyc(input logic r, input logic run, input logic step,
                     input logic [1:0] a, input logic en, input logic wrap,
                     input string tag);
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.run  = run;
    bus.step = step;
    e.a    = a;
    e.en   = en;
    e.wrap = wrap;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // one step from HOLD: a full blanked period at code na, then back to HOLD
  task automatic step_period(input logic [1:0] na);
    cyc(1'b0, 1'b0, 1'b1, na, scan_en(0), (na == 2'd0), "step_first");
    for (int k = 1; k < P; k++)
      cyc(1'b0, 1'b0, 1'b0, na, scan_en(k), 1'b0, "step_scan");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, na, 1'b1, 1'b0, "step_hold");
  endtask

  // monitor: compares DUT outputs each cycle against the scoreboard head
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({bus.a, bus.en, bus.wrap} !== {e.a, e.en, e.wrap}) begin
          failures++;
          $display("FAIL %s t=%0t: got a=%0d en=%b wrap=%b, expected a=%0d en=%b wrap=%b",
                   e.tag, $time, bus.a, bus.en, bus.wrap, e.a, e.en, e.wrap);
        end
      end
    end
  end

  initial begin
    rst      = 1'b1;
    bus.run  = 1'b0;
    bus.step = 1'b0;

    // reset held with run high
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "reset");

    // free run from IDLE: codes 0,1,2,3,0; wrap only at start of the second 0
    for (int p = 0; p < 5; p++)
      for (int k = 0; k < P; k++)
        cyc(1'b0, 1'b1, 1'b0, 2'(p % 4), scan_en(k), (k == 0 && p == 4), "freerun");

    // code 1: run dropped while cnt=5, step pulse in the tail is ignored
    for (int k = 0; k < P; k++)
      cyc(1'b0, (k < 6), (k == 6), 2'd1, scan_en(k), 1'b0, "drop_run");
    cyc(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, "hold_entry");
    for (int i = 0; i < 21; i++)
      cyc(1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, "hold");

    // single steps 1->2->3->0 (wrap on the last)
    step_period(2'd2);
    step_period(2'd3);
    step_period(2'd0);

    // run and step together from HOLD at 0: exactly one advance, then free run
    cyc(1'b0, 1'b1, 1'b1, 2'd1, scan_en(0), 1'b0, "run_step");
    for (int k = 1; k < P; k++)
      cyc(1'b0, 1'b1, 1'b0, 2'd1, scan_en(k), 1'b0, "run_step_scan");
    for (int p = 2; p < 4; p++)
      for (int k = 0; k < P; k++)
        cyc(1'b0, 1'b1, 1'b0, 2'(p), scan_en(k), 1'b0, "run_to_3");

    // reset sampled at cnt=7 with a=3 and run=1: wrap suppressed, back to IDLE
    cyc(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, "rst_at_last");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, "idle_step");

    // re-entry from IDLE into one full period and the first advance
    for (int k = 0; k < P; k++)
      cyc(1'b0, 1'b1, 1'b0, 2'd0, scan_en(k), 1'b0, "reentry");
    cyc(1'b0, 1'b1, 1'b0, 2'd1, scan_en(0), 1'b0, "reentry_adv");

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
